// File: rtl/unit_wave_scheduler.sv
// Game-tick phase generator, spawn-permit arbiter and friendly-slot reductions
// (battlefront minimum, per-tick saturating damage total).
module unit_wave_scheduler #(
    parameter int NUM_UNITS      = 4,
    parameter int TICK_DIV       = 16,
    parameter int SPAWN_COOLDOWN = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   spawn_btn,
    input  logic [NUM_UNITS-1:0]   slot_dead,
    input  logic [9*NUM_UNITS-1:0] slot_pos,
    input  logic [8*NUM_UNITS-1:0] slot_dmg,
    output logic [NUM_UNITS-1:0]   can_spawn,
    output logic                   move_scen,
    output logic                   damage_scen,
    output logic [8:0]             friendly_front,
    output logic [10:0]            total_damage,
    output logic                   cooldown_busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_MOVE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DAMAGE = 3'd4;
    localparam int CW = $clog2(TICK_DIV);

    logic [2:0]           r_state, w_state_nxt;
    logic [CW-1:0]        r_tick_cnt, w_cnt_nxt;
    logic [7:0]           r_cooldown;
    logic [NUM_UNITS-1:0] r_can_spawn, w_grant;
    logic                 r_move_scen, r_damage_scen;
    logic [8:0]           r_front, w_min;
    logic [10:0]          r_total;
    logic [15:0]          w_sum;
    logic                 w_spawn;
    logic                 w_found;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_tick_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_tick_cnt == CW'(TICK_DIV - 1)) begin
                    w_state_nxt = S_MOVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end
            // Once the move strobe is issued the tick always runs to damage.
            S_MOVE:   w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_DAMAGE;
            S_DAMAGE: w_state_nxt = enable ? S_WAIT : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_min   = 9'h1FF;
        w_sum   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (slot_dead[i] && !w_found) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
            if (!slot_dead[i]) begin
                if (slot_pos[9*i +: 9] < w_min) w_min = slot_pos[9*i +: 9];
                w_sum = w_sum + 16'(slot_dmg[8*i +: 8]);
            end
        end
    end

    assign w_spawn = spawn_btn && (r_can_spawn != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tick_cnt    <= '0;
            r_cooldown    <= '0;
            r_can_spawn   <= '0;
            r_move_scen   <= 1'b0;
            r_damage_scen <= 1'b0;
            r_front       <= 9'h1FF;
            r_total       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_cnt_nxt;
            r_move_scen   <= (r_state == S_MOVE);
            r_damage_scen <= (r_state == S_DAMAGE);
            r_front       <= w_min;
            // Sampled after the move strobe so slots' updated damage is included.
            if (r_state == S_SETTLE)
                r_total <= (w_sum > 16'h07FF) ? 11'h7FF : w_sum[10:0];
            // A spawn reload takes priority over the per-tick decrement.
            if (w_spawn)
                r_cooldown <= 8'(SPAWN_COOLDOWN);
            else if (r_state == S_MOVE && r_cooldown != 8'd0)
                r_cooldown <= r_cooldown - 8'd1;
            r_can_spawn <= (enable && r_cooldown == 8'd0 && !w_spawn) ? w_grant : '0;
        end
    end

    assign can_spawn      = r_can_spawn;
    assign move_scen      = r_move_scen;
    assign damage_scen    = r_damage_scen;
    assign friendly_front = r_front;
    assign total_damage   = r_total;
    assign cooldown_busy  = (r_cooldown != 8'd0);
endmodule

// File: tb/tb_unit_wave_scheduler.sv
// Directed bench for unit_wave_scheduler: tick timing, reductions, spawn arbiter, reset abort.
module tb_unit_wave_scheduler;
    logic        clk, reset_n, enable, spawn_btn;
    logic [3:0]  slot_dead;
    logic [35:0] slot_pos;
    logic [31:0] slot_dmg;
    logic [3:0]  can_spawn;
    logic        move_scen, damage_scen, cooldown_busy;
    logic [8:0]  friendly_front;
    logic [10:0] total_damage;

    logic [7:0]  dead8, cs8;
    logic [71:0] pos8;
    logic [63:0] dmg8;
    logic        mv8, dm8, cb8;
    logic [8:0]  ff8;
    logic [10:0] td8;

    logic [8:0]  dead9, cs9;
    logic [80:0] pos9;
    logic [71:0] dmg9;
    logic        mv9, dm9, cb9;
    logic [8:0]  ff9;
    logic [10:0] td9;

    int tests = 0;
    int fails = 0;
    int mq[$];
    int dq[$];
    int n_strobes;

    unit_wave_scheduler #(.NUM_UNITS(4), .TICK_DIV(16), .SPAWN_COOLDOWN(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .spawn_btn(spawn_btn),
        .slot_dead(slot_dead), .slot_pos(slot_pos), .slot_dmg(slot_dmg),
        .can_spawn(can_spawn), .move_scen(move_scen), .damage_scen(damage_scen),
        .friendly_front(friendly_front), .total_damage(total_damage),
        .cooldown_busy(cooldown_busy));

    unit_wave_scheduler #(.NUM_UNITS(8), .TICK_DIV(16), .SPAWN_COOLDOWN(8)) u8 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .spawn_btn(1'b0),
        .slot_dead(dead8), .slot_pos(pos8), .slot_dmg(dmg8),
        .can_spawn(cs8), .move_scen(mv8), .damage_scen(dm8),
        .friendly_front(ff8), .total_damage(td8), .cooldown_busy(cb8));

    // Nine slots of 8'hFF exceed 11 bits, exercising saturation.
    unit_wave_scheduler #(.NUM_UNITS(9), .TICK_DIV(16), .SPAWN_COOLDOWN(8)) u9 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .spawn_btn(1'b0),
        .slot_dead(dead9), .slot_pos(pos9), .slot_dmg(dmg9),
        .can_spawn(cs9), .move_scen(mv9), .damage_scen(dm9),
        .friendly_front(ff9), .total_damage(td9), .cooldown_busy(cb9));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_move(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_scen && n < 100);
        chk(tag, 32'(move_scen), 32'd1);
    endtask

    task automatic wait_dmg(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!damage_scen && n < 100);
        chk(tag, 32'(damage_scen), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; spawn_btn = 1'b0;
        slot_dead = 4'hF; slot_pos = '0; slot_dmg = '0;
        dead8 = '0; pos8 = '0; dmg8 = '1;
        dead9 = '0; pos9 = '0; dmg9 = '1;

        repeat (2) @(negedge clk);
        chk("rst_can_spawn", 32'(can_spawn), 32'h0);
        chk("rst_move", 32'(move_scen), 32'h0);
        chk("rst_damage", 32'(damage_scen), 32'h0);
        chk("rst_total", 32'(total_damage), 32'h0);
        chk("rst_front", 32'(friendly_front), 32'h1FF);
        chk("rst_busy", 32'(cooldown_busy), 32'h0);
        reset_n = 1'b1;

        // Cycle c = state after the c-th rising edge following release.
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (move_scen) mq.push_back(c);
            if (damage_scen) dq.push_back(c);
        end
        chk("move_count", 32'(mq.size()), 32'd3);
        chk("dmg_count", 32'(dq.size()), 32'd3);
        chk("move_t0", 32'(mq[0]), 32'd17);
        chk("move_t1", 32'(mq[1]), 32'd36);
        chk("move_t2", 32'(mq[2]), 32'd55);
        chk("dmg_t0", 32'(dq[0]), 32'd19);
        chk("dmg_t1", 32'(dq[1]), 32'd38);
        chk("dmg_t2", 32'(dq[2]), 32'd57);

        slot_dead = 4'b0000; slot_dmg = {4{8'hFF}};
        wait_dmg("dmg_wait_a");
        chk("total_4xFF", 32'(total_damage), 32'h3FC);
        chk("total_8xFF", 32'(td8), 32'h7F8);
        chk("total_9xFF_sat", 32'(td9), 32'h7FF);

        slot_dead = 4'b0101; slot_dmg = {8'h10, 8'h20, 8'h30, 8'h40};
        @(negedge clk);
        chk("total_hold", 32'(total_damage), 32'h3FC);
        wait_dmg("dmg_wait_b");
        chk("total_live_only", 32'(total_damage), 32'h040);

        slot_pos = {9'd40, 9'd100, 9'd7, 9'd300};
        slot_dead = 4'b0010;
        @(negedge clk);
        chk("front_skip_slot1", 32'(friendly_front), 32'd40);
        slot_dead = 4'b0100;
        @(negedge clk);
        chk("front_skip_slot2", 32'(friendly_front), 32'd7);
        slot_pos = {9'd40, 9'd7, 9'd7, 9'd300}; slot_dead = 4'b0000;
        @(negedge clk);
        chk("front_tie", 32'(friendly_front), 32'd7);
        slot_dead = 4'b1111;
        @(negedge clk);
        chk("front_all_dead", 32'(friendly_front), 32'h1FF);

        slot_dead = 4'b1010;
        @(negedge clk);
        chk("grant_lowest", 32'(can_spawn), 32'b0010);
        slot_dead = 4'b1000;
        @(negedge clk);
        chk("grant_moves", 32'(can_spawn), 32'b1000);
        slot_dead = 4'b1010;
        @(negedge clk);
        chk("grant_back", 32'(can_spawn), 32'b0010);

        // Spawn in S_WAIT, then count the cooldown down through 8 move strobes.
        wait_dmg("dmg_wait_c");
        spawn_btn = 1'b1;
        @(negedge clk);
        spawn_btn = 1'b0;
        chk("spawn_clears_grant", 32'(can_spawn), 32'h0);
        chk("spawn_busy", 32'(cooldown_busy), 32'h1);
        repeat (7) wait_move("cd_move");
        chk("cd_busy_after7", 32'(cooldown_busy), 32'h1);
        chk("cd_no_regrant", 32'(can_spawn), 32'h0);
        wait_move("cd_move8");
        chk("cd_idle_after8", 32'(cooldown_busy), 32'h0);
        @(negedge clk);
        chk("cd_regrant", 32'(can_spawn), 32'b0010);

        slot_dead = 4'b0000;
        @(negedge clk);
        spawn_btn = 1'b1;
        @(negedge clk);
        spawn_btn = 1'b0;
        @(negedge clk);
        chk("spawn_no_grant_no_load", 32'(cooldown_busy), 32'h0);

        // Spawn on the S_MOVE cycle: reload wins over the decrement.
        slot_dead = 4'b1010;
        wait_dmg("dmg_wait_d");
        repeat (16) @(negedge clk);
        spawn_btn = 1'b1;
        @(negedge clk);
        spawn_btn = 1'b0;
        chk("spawn_on_move_strobe", 32'(move_scen), 32'h1);
        chk("spawn_on_move_busy", 32'(cooldown_busy), 32'h1);
        repeat (7) wait_move("cdm_move");
        chk("cdm_busy_after7", 32'(cooldown_busy), 32'h1);
        wait_move("cdm_move8");
        chk("cdm_idle_after8", 32'(cooldown_busy), 32'h0);

        // Drop enable while in S_MOVE: tick still completes, then idles.
        wait_dmg("dmg_wait_e");
        repeat (16) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_move", 32'(move_scen), 32'h1);
        @(negedge clk);
        chk("drop_settle", 32'(damage_scen), 32'h0);
        @(negedge clk);
        chk("drop_damage", 32'(damage_scen), 32'h1);
        n_strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (move_scen || damage_scen) n_strobes++;
        end
        chk("drop_quiet", 32'(n_strobes), 32'd0);

        // Reset during S_SETTLE aborts the tick.
        enable = 1'b1;
        repeat (2) @(negedge clk);
        spawn_btn = 1'b1;
        @(negedge clk);
        spawn_btn = 1'b0;
        chk("pre_rst_busy", 32'(cooldown_busy), 32'h1);
        wait_move("pre_rst_move");
        reset_n = 1'b0;
        #1;
        chk("abort_move", 32'(move_scen), 32'h0);
        chk("abort_total", 32'(total_damage), 32'h0);
        chk("abort_front", 32'(friendly_front), 32'h1FF);
        chk("abort_can_spawn", 32'(can_spawn), 32'h0);
        chk("abort_busy", 32'(cooldown_busy), 32'h0);
        n_strobes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (damage_scen || move_scen) n_strobes++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (damage_scen || move_scen) n_strobes++;
        chk("abort_no_strobe", 32'(n_strobes), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
